// File: rtl/interval_timer_if.sv
// Handshake bundle between the traffic-light controller, the parameter store
// and the interval timer. The timer is the slave; the controller/store side is the master.
interface interval_timer_if #(
  parameter int VALUE_W = 5,
  parameter int CNT_W   = 5
);
  logic               start;
  logic [1:0]         sel;
  logic               abort;
  logic               tick_en;
  logic [1:0]         interval;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic [CNT_W-1:0]   remaining;
  logic               expired;
  logic               err;

  modport master (
    output start, sel, abort, tick_en, value,
    input  interval, busy, remaining, expired, err
  );

  modport slave (
    input  start, sel, abort, tick_en, value,
    output interval, busy, remaining, expired, err
  );
endinterface

// File: rtl/interval_timer.sv
// Requests an interval class from the parameter store, captures its length and
// counts it down on the time-unit strobe, flagging expiry with a one-cycle pulse.
module interval_timer #(
  parameter int VALUE_W = 5,
  parameter int CNT_W   = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  interval_timer_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_expired;
  logic             r_err;

  logic             w_value_zero;
  logic             w_last_tick;

  assign w_value_zero = (bus.value == '0);
  assign w_last_tick  = bus.tick_en && (r_remaining <= CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_sel       <= 2'b00;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_expired   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          // A start qualified by abort is dropped entirely, including the error pulse.
          if (bus.start && !bus.abort) begin
            if (bus.sel == SEL_ILLEGAL) begin
              r_err <= 1'b1;
            end else begin
              r_sel   <= bus.sel;
              r_state <= REQ;
              r_busy  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.abort) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
          end else if (w_value_zero) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_expired   <= 1'b1;
          end else begin
            r_remaining <= CNT_W'(bus.value);
            r_state     <= COUNT;
          end
        end
        COUNT: begin
          if (bus.abort) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
          end else if (w_last_tick) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_expired   <= 1'b1;
          end else if (bus.tick_en) begin
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_remaining <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interval  = r_sel;
  assign bus.busy      = r_busy;
  assign bus.remaining = r_remaining;
  assign bus.expired   = r_expired;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_interval_timer.sv
// Directed and randomized checks of interval_timer against a transaction-level
// model: expected remaining is the captured length minus the ticks seen so far.
module tb_interval_timer;
  localparam int VW = 5;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interval_timer_if #(.VALUE_W(VW), .CNT_W(CW)) bus ();

  interval_timer #(.VALUE_W(VW), .CNT_W(CW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  // The bench plays the parameter store: a combinational lookup by class.
  logic [VW-1:0] store_mem [4];
  assign bus.value = store_mem[bus.interval];

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] m_interval;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit e_busy, input int e_rem,
                            input bit e_exp, input bit e_err);
    chk({tag, ".busy"},      bus.busy,      e_busy);
    chk({tag, ".remaining"}, bus.remaining, e_rem);
    chk({tag, ".expired"},   bus.expired,   e_exp);
    chk({tag, ".err"},       bus.err,       e_err);
    chk({tag, ".interval"},  bus.interval,  m_interval);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.sel = 2'b00;
    bus.abort = 1'b0;
    bus.tick_en = 1'b0;
  endtask

  // abort_mode: 0 none, 1 abort during REQ, 2 abort on count cycle abort_cycle.
  task automatic run_txn(input logic [1:0] s, input int period, input int abort_mode,
                         input int abort_cycle, input bit reprog, input bit tick_in_req);
    int v;
    int ticks;
    bit done;
    bus.start = 1'b1;
    bus.sel = s;
    bus.abort = 1'b0;
    bus.tick_en = 1'b0;
    step();
    m_interval = s;
    bus.start = 1'b0;
    check_outs("req", 1'b1, 0, 1'b0, 1'b0);
    v = int'(store_mem[s]);
    bus.tick_en = tick_in_req;
    bus.abort = (abort_mode == 1);
    step();
    idle_inputs();
    if (abort_mode == 1) begin
      check_outs("abort_req", 1'b0, 0, 1'b0, 1'b0);
      step();
      check_outs("post_abort_req", 1'b0, 0, 1'b0, 1'b0);
      return;
    end
    if (v == 0) begin
      check_outs("zero_len", 1'b0, 0, 1'b1, 1'b0);
      step();
      check_outs("zero_len_after", 1'b0, 0, 1'b0, 1'b0);
      return;
    end
    check_outs("load", 1'b1, v, 1'b0, 1'b0);
    ticks = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      bus.tick_en = ((cyc % period) == period - 1);
      bus.abort = (abort_mode == 2) && (cyc == abort_cycle);
      // Starts (legal or not) while busy must be ignored silently.
      bus.start = ($urandom_range(0, 3) == 0);
      bus.sel = 2'($urandom_range(0, 3));
      if (reprog && cyc == 1) store_mem[s] = VW'($urandom_range(0, 31));
      step();
      if (bus.abort) begin
        check_outs("abort", 1'b0, 0, 1'b0, 1'b0);
        done = 1'b1;
      end else if (bus.tick_en) begin
        ticks++;
        if (ticks == v) begin
          check_outs("expire", 1'b0, 0, 1'b1, 1'b0);
          done = 1'b1;
        end else begin
          check_outs("tick", 1'b1, v - ticks, 1'b0, 1'b0);
        end
      end else begin
        check_outs("hold", 1'b1, v - ticks, 1'b0, 1'b0);
      end
    end
    idle_inputs();
    chk("cycle_budget", done, 1'b1);
    step();
    check_outs("idle_after", 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic illegal_start();
    bus.start = 1'b1;
    bus.sel = 2'b11;
    step();
    idle_inputs();
    check_outs("illegal", 1'b0, 0, 1'b0, 1'b1);
    step();
    check_outs("illegal_after", 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    idle_inputs();
    store_mem[0] = 5'd6;
    store_mem[1] = 5'd0;
    store_mem[2] = 5'd2;
    store_mem[3] = 5'd0;
    m_interval = 2'b00;
    #12;
    check_outs("reset", 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_outs("post_reset", 1'b0, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a count at remaining=3.
    store_mem[1] = 5'd5;
    bus.start = 1'b1;
    bus.sel = 2'b01;
    step();
    idle_inputs();
    m_interval = 2'b01;
    step();
    check_outs("rst_load", 1'b1, 5, 1'b0, 1'b0);
    bus.tick_en = 1'b1;
    step();
    step();
    bus.tick_en = 1'b0;
    check_outs("rst_pre", 1'b1, 3, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    m_interval = 2'b00;
    check_outs("async_reset", 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    store_mem[1] = 5'd0;

    // Directed scenarios.
    run_txn(2'b00, 1, 0, 0, 1'b0, 1'b1);   // 6 ticks back to back
    run_txn(2'b10, 4, 0, 0, 1'b0, 1'b0);   // length 2, tick every 4th cycle
    run_txn(2'b01, 1, 0, 0, 1'b0, 1'b0);   // zero length: immediate expiry
    illegal_start();
    store_mem[0] = 5'd3;
    run_txn(2'b00, 1, 2, 2, 1'b1, 1'b0);   // abort with tick at remaining=1
    store_mem[2] = 5'd31;
    run_txn(2'b10, 1, 0, 0, 1'b1, 1'b1);   // full-scale length, store reprogrammed

    // Abort or start+abort while idle has no effect.
    bus.abort = 1'b1;
    step();
    bus.start = 1'b1;
    bus.sel = 2'b11;
    step();
    idle_inputs();
    check_outs("idle_abort", 1'b0, 0, 1'b0, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] s;
      int am;
      s = 2'($urandom_range(0, 2));
      store_mem[s] = VW'($urandom_range(0, 12));
      am = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 5) == 0) illegal_start();
      run_txn(s, int'($urandom_range(1, 4)), am, int'($urandom_range(0, 20)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
